sqrt_sequencer: RTL and testbench

- Controller that runs the Newton-Raphson square root, x' = (A/x + x)/2, over a shared multi-cycle fp divider and a combinational fp adder.
- Owns the operand latch, the initial guess, the iteration count, IEEE special-case bypass and the start/done handshake toward the CPU.
- Sits between CPU issue logic and the fp datapath; the divider and adder stay external and unmodified.

---
 rtl/sqrt_sequencer.sv | 144 ++++++++++++++
 tb/tb_sqrt_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sequencer.sv
// Newton-Raphson square-root sequencer: drives an external multi-cycle fp divider
// and a combinational fp adder, handling IEEE special cases without iterating.
module sqrt_sequencer #(
    parameter int unsigned ITERS = 6,
    parameter int unsigned CNT_W = 4
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_q,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum
);
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_REQ,
        DIV_WAIT,
        ACCUM,
        DONE
    } state_t;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      POS_INF = 32'h7F80_0000;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITERS - 1);

    state_t           state;
    logic [31:0]      a_reg;
    logic [31:0]      guess;
    logic [31:0]      q_reg;
    logic [31:0]      res;
    logic [CNT_W-1:0] count;

    logic             a_sign;
    logic [7:0]       a_exp;
    logic [22:0]      a_man;
    logic [7:0]       guess_exp;
    logic [31:0]      halved;
    logic             special;
    logic [31:0]      special_res;

    assign a_sign    = a_reg[31];
    assign a_exp     = a_reg[30:23];
    assign a_man     = a_reg[22:0];
    assign guess_exp = 8'((9'(a_exp) + 9'd127) >> 1);

    // Halving is an exponent decrement; anything that would go subnormal flushes to signed zero.
    assign halved = (add_sum[30:23] <= 8'd1) ? {add_sum[31], 31'b0}
                                              : {add_sum[31], add_sum[30:23] - 8'd1, add_sum[22:0]};

    assign div_a = a_reg;
    assign div_b = guess;
    assign add_a = q_reg;
    assign add_b = guess;

    always_comb begin
        special     = 1'b1;
        special_res = '0;
        if (a_exp == 8'h00)
            special_res = {a_sign, 31'b0};
        else if (a_exp == 8'hFF && a_man != '0)
            special_res = QNAN;
        else if (a_sign)
            special_res = QNAN;
        else if (a_exp == 8'hFF)
            special_res = POS_INF;
        else
            special = 1'b0;
    end

    always_ff @(posedge cpu_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_start <= 1'b0;
            result    <= '0;
            res       <= '0;
            guess     <= '0;
            q_reg     <= '0;
            count     <= '0;
            a_reg     <= '0;
        end else begin
            done      <= 1'b0;
            div_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= operand;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (special) begin
                        res   <= special_res;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        guess     <= {1'b0, guess_exp, 23'b0};
                        count     <= '0;
                        div_start <= 1'b1;
                        state     <= DIV_REQ;
                    end
                end
                DIV_REQ: state <= DIV_WAIT;
                DIV_WAIT: begin
                    if (div_done) begin
                        q_reg <= div_q;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    guess <= halved;
                    if (count == LAST) begin
                        res   <= halved;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count     <= count + 1'b1;
                        div_start <= 1'b1;
                        state     <= DIV_REQ;
                    end
                end
                DONE: begin
                    result <= res;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_sequencer.sv
// Bench for sqrt_sequencer: real-arithmetic fp divider/adder models, a timeline
// reference model checked every cycle, and literal expectations for known cases.
`timescale 1ns/1ps
module tb_sqrt_sequencer;
    localparam int ITERS = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    always #5 clk = ~clk;

    sqrt_sequencer #(.ITERS(ITERS), .CNT_W(4)) dut (
        .cpu_clk  (clk),
        .rst_n    (rst_n),
        .start    (start),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_start(div_start),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_done (div_done),
        .div_q    (div_q),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- single-precision helpers (normal range, denormals flush) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [23:0] m;
        int          e;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        if (b[62:0] == '0 || e <= 0) return {b[63], 31'b0};
        m = {1'b0, b[51:29]};
        if (b[28] && ((b[27:0] != '0) || b[29])) m = m + 24'd1;
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'b0};
        return {b[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) / f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // sqrt by the Newton recurrence x' = (A/x + x)/2 in rounded single precision
    function automatic logic [31:0] model_sqrt(input logic [31:0] a, output bit sp);
        logic [31:0] x;
        sp = 1'b1;
        if (a[30:23] == 8'h00) return {a[31], 31'b0};
        if (a[30:23] == 8'hFF && a[22:0] != '0) return 32'h7FC0_0000;
        if (a[31]) return 32'h7FC0_0000;
        if (a[30:23] == 8'hFF) return 32'h7F80_0000;
        sp = 1'b0;
        x = {1'b0, 8'((int'(a[30:23]) + 127) / 2), 23'b0};
        for (int i = 0; i < ITERS; i++)
            x = r2f(f2r(fadd(fdiv(a, x), x)) * 0.5);
        return x;
    endfunction

    // Cycles spent in DIV_WAIT for a divider delay setting; 0 means div_done is already
    // up on entry, which still occupies one DIV_WAIT cycle.
    function automatic int wait_cycles(input int l);
        return (l < 1) ? 1 : l;
    endfunction

    // ---------------- external datapath models ----------------
    int lat_plan[ITERS];
    int div_idx = 0;

    always_comb add_sum = fadd(add_a, add_b);

    initial begin
        logic [31:0] q;
        int          l;
        div_done = 1'b0;
        div_q    = '0;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1 && rst_n === 1'b1) begin
                l = lat_plan[div_idx % ITERS];
                div_idx++;
                q = fdiv(div_a, div_b);
                if (l == 0) begin
                    div_done = 1'b1;
                    div_q    = q;
                    repeat (2) @(negedge clk);
                end else begin
                    repeat (l) @(negedge clk);
                    div_done = 1'b1;
                    div_q    = q;
                    @(negedge clk);
                end
                div_done = 1'b0;
            end
        end
    end

    // ---------------- reference timeline model ----------------
    int          phase = 0;
    int          tot   = 0;
    bit          model_live = 1'b0;
    bit          have_a = 1'b0;
    bit          ds_at[0:127];
    logic [31:0] m_a, m_res, m_hold;

    always @(posedge clk) begin
        bit sp;
        int off;
        if (rst_n === 1'b0) begin
            phase      = 0;
            m_hold     = '0;
            have_a     = 1'b0;
            model_live = 1'b1;
        end else if (phase == 0) begin
            if (start === 1'b1) begin
                m_a    = operand;
                have_a = 1'b1;
                m_res  = model_sqrt(operand, sp);
                for (int i = 0; i < 128; i++) ds_at[i] = 1'b0;
                if (sp) begin
                    tot = 2;
                end else begin
                    off = 2;
                    for (int i = 0; i < ITERS; i++) begin
                        ds_at[off] = 1'b1;
                        off += wait_cycles(lat_plan[i]) + 2;
                    end
                    tot = off;
                end
                phase = 1;
            end
        end else if (phase == tot) begin
            m_hold = m_res;
            phase  = 0;
        end else begin
            phase++;
        end
    end

    // one compare process: every cycle once reset has been applied
    always @(negedge clk) begin
        if (model_live) begin
            check("busy",      32'(busy),      32'(phase >= 1 && phase < tot));
            check("done",      32'(done),      32'(phase != 0 && phase == tot));
            check("div_start", 32'(div_start), 32'(phase != 0 && ds_at[phase]));
            check("result",    result,         m_hold);
            if (have_a) check("div_a", div_a, m_a);
        end
    end

    int ds_count   = 0;
    int done_count = 0;
    always @(negedge clk) begin
        if (div_start === 1'b1) ds_count++;
        if (done === 1'b1) done_count++;
    end

    // ---------------- stimulus ----------------
    task automatic set_plan(input int l);
        for (int i = 0; i < ITERS; i++) lat_plan[i] = l;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_op(input logic [31:0] a, output int lat, output logic [31:0] r);
        int k;
        ds_count = 0;
        div_idx  = 0;
        operand  = a;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        operand = $urandom;
        k = 1;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        lat = k;
        @(negedge clk);
        r = result;
    endtask

    logic [31:0] spec_in  [5] = '{32'h0000_0000, 32'h8000_0000, 32'hC080_0000, 32'h7F80_0000, 32'h7F80_0001};
    logic [31:0] spec_out [5] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000};
    int          var_plan [6] = '{1, 7, 0, 1, 7, 0};

    initial begin
        int          lat;
        int          k;
        int          diff;
        logic [31:0] r;
        logic [31:0] a;
        rst_n   = 1'b0;
        start   = 1'b0;
        operand = '0;
        set_plan(3);
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_dstart", 32'(div_start), 32'd0);
        check("rst_result", result,         32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4.0 is a fixed point of the initial guess 2.0
        run_op(32'h4080_0000, lat, r);
        check("four_lat", lat, 32);
        check("four_res", r, 32'h4000_0000);
        check("four_ds",  ds_count, 6);

        run_op(32'h4000_0000, lat, r);
        diff = int'(r) - int'(32'h3FB5_04F3);
        if (diff < 0) diff = -diff;
        n_checks++;
        if (diff > 1) begin
            n_fail++;
            $display("FAIL sqrt2_ulp: got %h expected within 1 ulp of 3fb504f3", r);
        end

        for (int i = 0; i < 5; i++) begin
            run_op(spec_in[i], lat, r);
            check("spec_lat", lat, 2);
            check("spec_res", r, spec_out[i]);
            check("spec_ds",  ds_count, 0);
        end

        // DIV_WAIT lengths 1,7,1,1,7,1 -> 1 + (3+9+3+3+9+3) + 1 = 32
        for (int i = 0; i < ITERS; i++) lat_plan[i] = var_plan[i];
        run_op(32'h4110_0000, lat, r);
        check("nine_lat", lat, 32);
        check("nine_res", r, 32'h4040_0000);
        set_plan(3);

        // start held high with a changing operand; held through DONE, 9.0 offered in IDLE
        done_count = 0;
        div_idx    = 0;
        operand    = 32'h4080_0000;
        start      = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            operand = $urandom;
            k++;
        end while (done !== 1'b1 && k < 200);
        check("hammer_done", 32'(done), 32'd1);
        operand = 32'h4110_0000;
        @(negedge clk);
        check("hammer_res4",   result, 32'h4000_0000);
        check("hammer_dcount", done_count, 1);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("hammer_done2", 32'(done), 32'd1);
        @(negedge clk);
        check("hammer_res9",    result, 32'h4040_0000);
        check("hammer_dcount2", done_count, 2);

        // reset while the third division is outstanding
        ds_count = 0;
        div_idx  = 0;
        operand  = 32'h4080_0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (ds_count < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach", 32'(ds_count >= 3), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", result,    32'h0);
        repeat (6) @(negedge clk);
        check("stale_busy", 32'(busy), 32'd0);
        run_op(32'h4080_0000, lat, r);
        check("fresh_lat", lat, 32);
        check("fresh_res", r, 32'h4000_0000);

        // randomized operands and divider delays
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < ITERS; i++) lat_plan[i] = $urandom_range(0, 4);
            case ($urandom_range(0, 9))
                0:       a = {1'($urandom), 8'h00, 23'($urandom)};
                1:       a = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
                2:       a = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
                3:       a = {1'($urandom), 8'hFF, 23'd0};
                default: a = {1'b0, 8'($urandom_range(20, 230)), 23'($urandom)};
            endcase
            run_op(a, lat, r);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
